// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size encodings, default map constants and response type for the data memory unit
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } mem_size_e;

    localparam logic [31:0] DEF_BASE_ADDR   = 32'h8002_0000;
    localparam int unsigned DEF_DEPTH_BYTES = 1048576;

    typedef struct packed {
        logic        v;
        logic        mis;
        logic        rng;
        logic [31:0] data;
    } rsp_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_WORD: return lane != 2'b00;
            SZ_HALF: return lane[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - big-endian lane select and sign/zero extension of a loaded word
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    always_comb begin
        half_lane = addr[1] ? raw[15:0] : raw[31:16];
        case (addr)
            2'd0:    byte_lane = raw[31:24];
            2'd1:    byte_lane = raw[23:16];
            2'd2:    byte_lane = raw[15:8];
            default: byte_lane = raw[7:0];
        endcase
        case (size)
            SZ_WORD: result = raw;
            SZ_HALF: result = {{16{half_lane[15] & ~uns}}, half_lane};
            SZ_BYTE: result = {{24{byte_lane[7] & ~uns}}, byte_lane};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - byte-addressed big-endian data memory with fixed-latency loads and error reporting
module mem_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES  = DEF_DEPTH_BYTES,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] address,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] data_in,
    input  logic [31:0] fwd_data,
    input  logic        fwd_sel,
    input  logic        flush,
    output logic        busy,
    output logic        valid,
    output logic [31:0] data_out,
    output logic        misaligned,
    output logic        range_err
);

    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int WORDS = DEPTH_BYTES / 4;

    logic [31:0] mem [WORDS];
    rsp_t        pipe [READ_LATENCY];
    logic [31:0] held_data;

    logic [31:0] off;
    logic [AW-3:0] idx;
    logic        mis, rng, err, accept;
    logic [31:0] raw_word, wdata, lane_data, load_result;
    logic [3:0]  be;
    rsp_t        entry;

    mem_load_align u_align (
        .raw    (raw_word),
        .addr   (address[1:0]),
        .size   (size),
        .uns    (load_unsigned),
        .result (load_result)
    );

    always_comb begin
        off      = address - BASE_ADDR;
        idx      = off[AW-1:2];
        mis      = is_misaligned(size, address[1:0]);
        rng      = off >= DEPTH_BYTES;
        err      = mis | rng;
        busy     = 1'b0;
        for (int k = 0; k < READ_LATENCY - 1; k++) busy = busy | pipe[k].v;
        accept   = enable & ~busy & ~flush & ~reset;
        raw_word = mem[idx];
        wdata    = fwd_sel ? fwd_data : data_in;
        // be[b] selects byte b of the word, byte 0 being bits [31:24]
        case (size)
            SZ_WORD: begin lane_data = wdata;                      be = 4'b1111; end
            SZ_HALF: begin lane_data = {wdata[15:0], wdata[15:0]}; be = address[1] ? 4'b1100 : 4'b0011; end
            SZ_BYTE: begin lane_data = {4{wdata[7:0]}};            be = 4'b0001 << address[1:0]; end
            default: begin lane_data = wdata;                      be = 4'b0000; end
        endcase
        entry.v    = 1'b1;
        entry.mis  = mis;
        entry.rng  = rng;
        entry.data = err ? 32'h0 : load_result;
    end

    always_ff @(posedge clock) begin
        if (accept && !rw && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][31-8*b -: 8] <= lane_data[31-8*b -: 8];
            end
        end
    end

    // Store errors enter at the last stage so they respond one cycle after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < READ_LATENCY; k++) pipe[k] <= '0;
            held_data <= '0;
        end else begin
            for (int k = READ_LATENCY - 1; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= '0;
            if (accept && rw)       pipe[0] <= entry;
            else if (accept && err) pipe[READ_LATENCY-1] <= entry;
            if (flush && busy) begin
                for (int k = 0; k < READ_LATENCY; k++) pipe[k] <= '0;
                held_data <= '0;
            end else if (pipe[READ_LATENCY-1].v) begin
                held_data <= pipe[READ_LATENCY-1].data;
            end
        end
    end

    assign valid      = pipe[READ_LATENCY-1].v;
    assign data_out   = valid ? pipe[READ_LATENCY-1].data : held_data;
    assign misaligned = valid & pipe[READ_LATENCY-1].mis;
    assign range_err  = valid & pipe[READ_LATENCY-1].rng;

endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - scoreboard bench for mem_unit against a byte-array reference model
module tb_mem_unit;

    localparam int          RL    = 3;
    localparam logic [31:0] BASE  = 32'h8002_0000;
    localparam logic [31:0] DEPTH = 32'd1048576;

    typedef struct {
        int          edge_no;
        logic [31:0] data;
        bit          mis;
        bit          rng;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] address = '0;
    logic [1:0]  size = '0;
    logic        load_unsigned = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] fwd_data = '0;
    logic        fwd_sel = 1'b0;
    logic        flush = 1'b0;
    logic        busy, valid, misaligned, range_err;
    logic [31:0] data_out;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          mon_en = 0;
    int          hold_zero_at = -1;
    logic [31:0] exp_hold = '0;
    bit          inflight = 0;
    int          inflight_m = 0;
    exp_t        sbq[$];
    logic [7:0]  ref_mem [logic [31:0]];

    mem_unit #(.READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset), .enable(enable), .rw(rw), .address(address),
        .size(size), .load_unsigned(load_unsigned), .data_in(data_in), .fwd_data(fwd_data),
        .fwd_sel(fwd_sel), .flush(flush), .busy(busy), .valid(valid), .data_out(data_out),
        .misaligned(misaligned), .range_err(range_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %h want %h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return ref_mem.exists(a) ? 32'(ref_mem[a]) : 32'h0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        case (sz)
            2'b00: v = rd(a) * 32'd16777216 + rd(a + 1) * 32'd65536 + rd(a + 2) * 32'd256 + rd(a + 3);
            2'b01: begin
                v = rd(a) * 32'd256 + rd(a + 1);
                if (!uns && v >= 32'd32768) v = v - 32'd65536;
            end
            default: begin
                v = rd(a);
                if (!uns && v >= 32'd128) v = v - 32'd256;
            end
        endcase
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = 8'(wd >> (24 - 8 * i));
            2'b01:   begin ref_mem[a] = wd[15:8]; ref_mem[a + 1] = wd[7:0]; end
            default: ref_mem[a] = wd[7:0];
        endcase
    endfunction

    function automatic void drop_from(input int n);
        while (sbq.size() > 0 && sbq[$].edge_no >= n) void'(sbq.pop_back());
    endfunction

    task automatic do_cycle(input bit en, input bit r, input logic [31:0] a, input logic [1:0] sz,
                            input bit uns, input logic [31:0] din, input logic [31:0] fwd,
                            input bit fsel, input bit fl, input bit rst,
                            input bit use_want = 0, input logic [31:0] want = 0);
        int   n;
        bit   mbusy, mis, rng;
        exp_t e;
        @(negedge clock);
        #1;
        n = cyc + 1;
        mbusy = inflight && (cyc <= inflight_m + RL - 2);
        if (!mbusy) inflight = 0;
        if (mon_en) check("busy", 32'(busy), 32'(mbusy));
        reset = rst; enable = en; rw = r; address = a; size = sz; load_unsigned = uns;
        data_in = din; fwd_data = fwd; fwd_sel = fsel; flush = fl;
        mis = (sz == 2'b11) || (sz == 2'b00 && a % 4 != 0) || (sz == 2'b01 && a % 2 != 0);
        rng = (a - BASE) >= DEPTH;
        if (rst) begin
            drop_from(n); hold_zero_at = n; inflight = 0;
        end else if (fl) begin
            if (mbusy) begin drop_from(n); hold_zero_at = n; inflight = 0; end
        end else if (en && !mbusy) begin
            if (r) begin
                e.edge_no = n + RL - 1; e.mis = mis; e.rng = rng;
                e.data = use_want ? want : ((mis || rng) ? 32'h0 : model_load(a, sz, uns));
                sbq.push_back(e);
                inflight = 1; inflight_m = n;
            end else if (mis || rng) begin
                e.edge_no = n; e.mis = mis; e.rng = rng; e.data = 32'h0;
                sbq.push_back(e);
            end else begin
                model_store(a, sz, fsel ? fwd : din);
            end
        end
    endtask

    task automatic idle();
        do_cycle(0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input bit uns,
                           input bit use_want, input logic [31:0] want);
        do_cycle(1, 1, a, sz, uns, 32'h0, 32'h0, 0, 0, 0, use_want, want);
        repeat (RL - 1) idle();
    endtask

    task automatic rand_cycle();
        int          k;
        logic [31:0] a;
        k = int'($urandom_range(0, 15));
        if (k == 0)      a = 32'h7FFF_FFFC;
        else if (k == 1) a = BASE + DEPTH + $urandom_range(0, 7);
        else if (k == 2) a = $urandom() & 32'h7FFF_FFFF;
        else             a = BASE + $urandom_range(0, 63);
        do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom(), $urandom(), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            if (cyc == hold_zero_at) exp_hold = 32'h0;
            if (valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_valid", 32'(valid), 32'h0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_edge", 32'(cyc), 32'(e.edge_no));
                    check("rsp_data", data_out, e.data);
                    check("rsp_misaligned", 32'(misaligned), 32'(e.mis));
                    check("rsp_range_err", 32'(range_err), 32'(e.rng));
                    exp_hold = e.data;
                end
            end else begin
                check("hold_data", data_out, exp_hold);
                check("idle_flags", {30'h0, misaligned, range_err}, 32'h0);
                if (sbq.size() > 0 && sbq[0].edge_no < cyc) begin
                    check("missed_valid", 32'(valid), 32'h1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        do_cycle(0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 1);
        mon_en = 1;
        do_cycle(0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 16; i++)
            do_cycle(1, 0, BASE + 32'(4 * i), 2'b00, 0, $urandom(), 32'h0, 0, 0, 0);

        do_cycle(1, 0, BASE, 2'b00, 0, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        do_load(BASE + 0, 2'b10, 1, 1, 32'h0000_00DE);
        do_load(BASE + 1, 2'b10, 1, 1, 32'h0000_00AD);
        do_load(BASE + 2, 2'b10, 1, 1, 32'h0000_00BE);
        do_load(BASE + 3, 2'b10, 1, 1, 32'h0000_00EF);
        do_load(BASE + 0, 2'b10, 0, 1, 32'hFFFF_FFDE);
        do_load(BASE + 1, 2'b10, 0, 1, 32'hFFFF_FFAD);
        do_load(BASE + 2, 2'b10, 0, 1, 32'hFFFF_FFBE);
        do_load(BASE + 3, 2'b10, 0, 1, 32'hFFFF_FFEF);

        do_cycle(1, 0, BASE + 2, 2'b01, 0, 32'h0000_8001, 32'h0000_1234, 1, 0, 0);
        do_load(BASE + 2, 2'b01, 0, 1, 32'h0000_1234);
        do_load(BASE, 2'b00, 0, 1, 32'hDEAD_1234);

        do_cycle(1, 1, BASE + 4, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
        do_cycle(1, 0, BASE, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
        do_cycle(1, 0, BASE, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
        do_load(BASE, 2'b00, 0, 1, 32'hDEAD_1234);

        do_load(BASE + 1, 2'b00, 0, 1, 32'h0);
        do_load(32'h7FFF_FFFC, 2'b00, 0, 1, 32'h0);
        do_cycle(1, 0, 32'h8012_0000, 2'b00, 0, 32'h1111_1111, 32'h0, 0, 0, 0);
        do_load(BASE, 2'b00, 0, 1, 32'hDEAD_1234);

        do_cycle(1, 1, BASE + 4, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
        do_cycle(0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0, 0, 1, 0);
        do_load(BASE, 2'b00, 0, 1, 32'hDEAD_1234);

        do_cycle(1, 1, BASE + 8, 2'b00, 0, 32'h0, 32'h0, 0, 0, 0);
        do_cycle(0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 1);
        idle();
        do_load(BASE, 2'b00, 0, 1, 32'hDEAD_1234);

        for (int i = 0; i < 800; i++) rand_cycle();

        repeat (RL + 2) idle();
        check("drain_empty", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 The block SHALL have parameter DEPTH_BYTES, default 1048576, giving the byte-array size (power of two).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h80020000, giving the byte address mapped to array index 0.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal 1..4, giving the number of cycles from read acceptance to the valid data cycle.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  request strobe.
REQ-007 rw  in  1  1 = read (load), 0 = write (store).
REQ-008 address  in  32  byte address.
REQ-009 size  in  2  access size: 00 = word, 01 = half, 10 = byte, 11 = reserved (treated as misaligned).
REQ-010 load_unsigned  in  1  1 = zero-extend a half/byte load, 0 = sign-extend.
REQ-011 data_in  in  32  store data, right-justified.
REQ-012 fwd_data  in  32  writeback forwarding value.
REQ-013 fwd_sel  in  1  1 = store fwd_data instead of data_in.
REQ-014 flush  in  1  branch/squash: kills any in-flight read.
REQ-015 busy  out  1  a read is in flight; new requests are not accepted.
REQ-016 valid  out  1  one-cycle pulse qualifying data_out and the error flags.
REQ-017 data_out  out  32  load result, extended to 32 bits.
REQ-018 misaligned  out  1  the reported access was misaligned or used a reserved size.
REQ-019 range_err  out  1  the reported access was outside [BASE_ADDR, BASE_ADDR+DEPTH_BYTES).

Function
REQ-020 A request SHALL be accepted on a clock edge where enable=1, busy=0 and flush=0; enable is ignored while busy=1.
REQ-021 Byte order SHALL be big-endian: word byte 0 at the lowest address holds bits [31:24]; a half at address A holds bits [15:8] at A.
REQ-022 An accepted store SHALL commit in the acceptance cycle, writing 4, 2 or 1 bytes per size; no other byte changes; busy stays 0; valid pulses the next cycle only if an error flag is set.
REQ-023 An accepted load SHALL raise busy from the next cycle and return data_out with valid=1 exactly READ_LATENCY cycles after acceptance; busy drops in that same cycle.
REQ-024 The word addressed by a load SHALL be sampled at acceptance; a store accepted in a later cycle SHALL NOT affect it.
REQ-025 Half and byte loads SHALL sign- or zero-extend per load_unsigned, as captured at acceptance.
REQ-026 Misalignment is defined as: half with address[0]=1; word with address[1:0]!=0; or size=11.
REQ-027 A misaligned or out-of-range access SHALL NOT write memory; it SHALL report its error flag with valid=1 and data_out=0 at the normal response cycle (stores: the cycle after acceptance).
REQ-028 Range SHALL be checked as (address - BASE_ADDR) >= DEPTH_BYTES using 32-bit unsigned wrap; both flags may be set together.
REQ-029 While flush=1, any in-flight load SHALL be cancelled: no valid pulse; data_out forced to 0; busy=0 on the next cycle; a request presented with flush=1 is not accepted.
REQ-030 Outside valid cycles, data_out SHALL hold its last value, and misaligned and range_err SHALL be 0.

Reset
REQ-031 reset=1 SHALL force busy=0, valid=0, data_out=0, misaligned=0 and range_err=0 at the next edge, and abort any in-flight load without a response.
REQ-032 Memory array contents SHALL NOT be cleared by reset.
REQ-033 reset SHALL take priority over flush and enable.

Structure
REQ-034 Package mem_pkg SHALL hold the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD) and the default BASE_ADDR and DEPTH_BYTES constants.
REQ-035 The lane-select and extension logic SHALL be the sub-module mem_load_align (inputs: raw word, addr[1:0], size, unsigned; output: 32-bit result), shared with future fetch paths.
REQ-036 The read-latency pipeline SHALL be a READ_LATENCY-deep shift of {valid, flags, result}.

Verification
REQ-037 Word write of 32'hDEADBEEF to 32'h80020000, then byte loads at +0..+3 -> DE, AD, BE, EF; byte loads with load_unsigned=0 -> 32'hFFFFFFDE, FFFFFFAD, FFFFFFBE, FFFFFFEF.
REQ-038 Half store of 32'h00008001 at 32'h80020002 with fwd_sel=1 and fwd_data=32'h00001234 -> signed half load returns 32'h00001234; word at 32'h80020000 reads 32'hDEAD1234.
REQ-039 READ_LATENCY=3, load accepted at cycle t -> busy=1 at t+1 and t+2, valid=1 at t+3; enable held through t+1..t+2 is ignored.
REQ-040 Load at 32'h80020001 with size=00 -> valid with misaligned=1 and data_out=0; load at 32'h7FFFFFFC -> range_err=1; a store to 32'h80120000 leaves memory unchanged.
REQ-041 flush at t+1 of an in-flight load -> no valid pulse, busy=0 at t+2, and a new load accepted at t+2 returns correct data.
REQ-042 reset asserted mid-load -> no response and all outputs 0; previously stored data remains readable after reset.
